if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch front end of the LEGv8 pipeline. Owns the PC register and
//  next-PC selection, drives the combinational instruction memory address, and
//  captures the returned word into the IF/ID pipeline register (pc, inst, valid)
//  for the decode stage. Supports hazard stall, branch redirect and IF/ID flush,
//  and keeps a fetch counter for performance debug.
// PARAMETERS
//  RESET_PC   64'h0         PC value loaded on reset
//  NOP_INST   32'hD503201F  encoding inserted into IF/ID on flush/reset (LEGv8 NOP)
//  CNT_W      32            width of fetch_cnt performance counter
// PORTS
//  clk          in   1           pipeline clock, all state on rising edge
//  rst          in   1           asynchronous, active-high reset
//  stall        in   1           hazard unit: hold PC and IF/ID contents
//  flush        in   1           control: invalidate IF/ID on next edge
//  br_taken     in   1           resolved branch/jump from EX/MEM: redirect PC
//  br_target    in   `WORD       redirect target byte address
//  pc           out  `WORD       current fetch address, to instruction memory
//  inst_in      in   `INST_SIZE  instruction word returned for pc (same cycle)
//  ifid_pc      out  `WORD       PC of instruction held in IF/ID
//  ifid_inst    out  `INST_SIZE  instruction held in IF/ID
//  ifid_valid   out  1           IF/ID holds a real (non-bubble) instruction
//  fetch_cnt    out  CNT_W       number of valid instructions written into IF/ID
// BEHAVIOUR
//  Reset (async, any time incl. mid-stall/mid-redirect):
//   pc=RESET_PC, ifid_pc=0, ifid_inst=NOP_INST, ifid_valid=0, fetch_cnt=0.
//   First edge after rst deasserts captures inst_in for RESET_PC into IF/ID.
//  Memory read is combinational: inst_in valid in same cycle pc is driven;
//   instruction at PC p appears in IF/ID one cycle after pc==p (latency 1).
//  Per rising edge, priority high->low:
//   1 br_taken: pc<=br_target & ~64'h3 (low 2 bits forced 0); IF/ID<=bubble
//     (inst=NOP_INST, valid=0, ifid_pc=0). Overrides stall and flush.
//   2 stall (no br_taken): pc, ifid_* and fetch_cnt all hold. stall+flush ->
//     IF/ID<=bubble, pc holds.
//   3 flush only: IF/ID<=bubble, pc<=pc+4.
//   4 normal: ifid_pc<=pc, ifid_inst<=inst_in, ifid_valid<=1, pc<=pc+4.
//  pc+4 computed modulo 2^`WORD: pc=64'hFFFF_FFFF_FFFF_FFFC wraps to 0, no flag.
//  fetch_cnt increments by 1 only on case 4 edges; saturates at all-ones (no wrap).
//  Bubble cycles (valid=0) never advance fetch_cnt.
//  State: PC reg, IF/ID reg, counter; outputs are registers (pc drives memory
//   directly from the PC register, no combinational path from inputs to pc).
//  Stall held N cycles: same ifid_inst presented N+1 cycles; pc unchanged.
//  br_taken held multiple cycles: each edge reloads br_target, IF/ID stays bubble.
// TESTING
//  T1 reset, mem[0..3]=A,B,C,D, no stall -> pc 0,4,8,12; ifid_inst A,B,C one cycle
//     behind; ifid_valid 0 then 1; fetch_cnt 1,2,3.
//  T2 stall asserted 3 cycles at pc=8 -> pc stays 8, ifid_inst=B for 4 cycles,
//     fetch_cnt frozen; release -> C captured, pc=12.
//  T3 br_taken with br_target=0x43 while stall=1 -> next pc=0x40, ifid_valid=0,
//     ifid_inst=0xD503201F; following edge captures mem[0x10].
//  T4 flush alone at pc=4 -> IF/ID bubble, pc=8, fetch_cnt unchanged;
//     stall+flush -> bubble, pc held.
//  T5 force pc=64'hFFFF_FFFF_FFFF_FFFC via br_taken -> next pc=0; CNT_W=4 run
//     20 fetches -> fetch_cnt sticks at 4'hF.
//  T6 assert rst asynchronously mid-stall (between edges) -> outputs reach reset
//     values immediately, without waiting for clk.

Source files
------------

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module   : if_fetch_unit
// Brief    : LEGv8 instruction-fetch stage: PC register, next-PC select and
//            IF/ID pipeline register with stall, redirect, flush and counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INST = 32'hD503201F,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_taken,
    input  logic [63:0]      br_target,
    output logic [63:0]      pc,
    input  logic [31:0]      inst_in,
    output logic [63:0]      ifid_pc,
    output logic [31:0]      ifid_inst,
    output logic             ifid_valid,
    output logic [CNT_W-1:0] fetch_cnt
);

    logic [63:0]      r_pc;
    logic [63:0]      r_ifid_pc;
    logic [31:0]      r_ifid_inst;
    logic             r_ifid_valid;
    logic [CNT_W-1:0] r_fetch_cnt;

    logic [63:0]      w_pc_plus4;
    logic             w_capture;
    logic             w_bubble;
    logic             w_cnt_full;

    assign w_pc_plus4 = r_pc + 64'd4;
    assign w_capture  = ~br_taken & ~stall & ~flush;
    // A redirect always squashes; a flush squashes even while stalled.
    assign w_bubble   = br_taken | flush;
    assign w_cnt_full = &r_fetch_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (br_taken) begin
            r_pc <= {br_target[63:2], 2'b00};
        end else if (!stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifid_pc    <= 64'h0;
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
        end else if (w_bubble) begin
            r_ifid_pc    <= 64'h0;
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
        end else if (w_capture) begin
            r_ifid_pc    <= r_pc;
            r_ifid_inst  <= inst_in;
            r_ifid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
        end else if (w_capture && !w_cnt_full) begin
            r_fetch_cnt <= r_fetch_cnt + 1'b1;
        end
    end

    assign pc         = r_pc;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_inst  = r_ifid_inst;
    assign ifid_valid = r_ifid_valid;
    assign fetch_cnt  = r_fetch_cnt;

endmodule

`default_nettype wire
